// File: rtl/mips32_prog_loader_if.sv
// Byte-stream input, instruction-memory and register-bank write bus of the MIPS32 program loader.
// The master modport is the loader side; the slave modport is the host/memory side.
interface mips32_prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              rf_we;
    logic [4:0]        rf_addr;
    logic [31:0]       rf_wdata;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata, rf_we, rf_addr, rf_wdata
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata, rf_we, rf_addr, rf_wdata
    );
endinterface

// File: rtl/mips32_prog_loader.sv
// MIPS32 boot loader: big-endian byte stream -> count header + program words into instruction memory,
// then releases the core. Optional REGBANK_INIT_EN adds a 32-cycle register-bank init (Rk = k).
module mips32_prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int MEM_DEPTH = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic                 i_clk1,
    input  logic                 i_reset,
    mips32_prog_loader_if.master io_bus,
    output logic                 o_cpu_hold,
    output logic                 o_cpu_start,
    output logic                 o_load_err,
    output logic [ADDR_W:0]      o_words_loaded
);

`ifdef REGBANK_INIT_EN
    typedef enum logic [2:0] {
        S_HDR    = 3'd0,
        S_LOAD   = 3'd1,
        S_DONE   = 3'd2,
        S_ERR    = 3'd3,
        S_RFINIT = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_LOAD = 3'd1,
        S_DONE = 3'd2,
        S_ERR  = 3'd3
    } state_t;
`endif

    localparam logic [31:0] MAX_N = 32'(MEM_DEPTH - BASE_ADDR);

    state_t            r_state;
    state_t            w_next;
    logic              r_rx_ready;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_partial;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_words_loaded;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_cpu_hold;
    logic              r_cpu_start;
    logic              r_load_err;

    logic              w_accept;
    logic              w_word_done;
    logic [31:0]       w_word;
    logic              w_hdr_ok;
    logic              w_last;

    assign w_accept    = io_bus.rx_valid & r_rx_ready;
    assign w_word_done = w_accept & (r_byte_cnt == 2'd3);
    assign w_word      = {r_partial, io_bus.rx_data};
    assign w_hdr_ok    = (w_word != 32'd0) && (w_word <= MAX_N);
    assign w_last      = ((r_words_loaded + (ADDR_W+1)'(1)) == r_count);

`ifdef REGBANK_INIT_EN
    logic [4:0]  r_rf_cnt;
    logic        r_rf_we;
    logic [4:0]  r_rf_addr;
    logic [31:0] r_rf_wdata;
`endif

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HDR: begin
                if (w_word_done) begin
                    if (w_hdr_ok) begin
                        w_next = S_LOAD;
                    end else begin
                        w_next = S_ERR;
                    end
                end else begin
                    w_next = S_HDR;
                end
            end
            S_LOAD: begin
                if (w_word_done && w_last) begin
`ifdef REGBANK_INIT_EN
                    w_next = S_RFINIT;
`else
                    w_next = S_DONE;
`endif
                end else begin
                    w_next = S_LOAD;
                end
            end
`ifdef REGBANK_INIT_EN
            S_RFINIT: begin
                if (r_rf_cnt == 5'd31) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_RFINIT;
                end
            end
`endif
            S_DONE:  w_next = S_DONE;
            S_ERR:   w_next = S_ERR;
            default: w_next = S_ERR;
        endcase
    end

    // State register
    always_ff @(posedge i_clk1) begin
        if (i_reset) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_next;
        end
    end

    // Byte assembly, memory write port and core control outputs
    always_ff @(posedge i_clk1) begin
        if (i_reset) begin
            r_rx_ready     <= 1'b1;
            r_byte_cnt     <= 2'd0;
            r_partial      <= 24'd0;
            r_count        <= '0;
            r_words_loaded <= '0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= 32'd0;
            r_cpu_hold     <= 1'b1;
            r_cpu_start    <= 1'b0;
            r_load_err     <= 1'b0;
        end else begin
            r_rx_ready  <= (w_next == S_HDR) || (w_next == S_LOAD);
            r_load_err  <= (w_next == S_ERR);
            // Start pulse is the first cycle in which the hold is released
            r_cpu_hold  <= (r_state != S_DONE);
            r_cpu_start <= (r_state == S_DONE) && r_cpu_hold;
            r_mem_we    <= 1'b0;
            if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                if (r_byte_cnt == 2'd3) begin
                    r_partial <= 24'd0;
                end else begin
                    r_partial <= {r_partial[15:0], io_bus.rx_data};
                end
            end
            if (w_word_done && (r_state == S_HDR) && w_hdr_ok) begin
                r_count <= w_word[ADDR_W:0];
            end
            if (w_word_done && (r_state == S_LOAD)) begin
                r_mem_we       <= 1'b1;
                r_mem_addr     <= ADDR_W'(BASE_ADDR) + r_words_loaded[ADDR_W-1:0];
                r_mem_wdata    <= w_word;
                r_words_loaded <= r_words_loaded + (ADDR_W+1)'(1);
            end
        end
    end

`ifdef REGBANK_INIT_EN
    // Register-bank init sequencer: Rk <= k for k = 0..31
    always_ff @(posedge i_clk1) begin
        if (i_reset) begin
            r_rf_cnt   <= 5'd0;
            r_rf_we    <= 1'b0;
            r_rf_addr  <= 5'd0;
            r_rf_wdata <= 32'd0;
        end else begin
            r_rf_we <= (r_state == S_RFINIT);
            if (r_state == S_RFINIT) begin
                r_rf_addr  <= r_rf_cnt;
                r_rf_wdata <= {27'd0, r_rf_cnt};
                r_rf_cnt   <= r_rf_cnt + 5'd1;
            end
        end
    end

    assign io_bus.rf_we    = r_rf_we;
    assign io_bus.rf_addr  = r_rf_addr;
    assign io_bus.rf_wdata = r_rf_wdata;
`else
    assign io_bus.rf_we    = 1'b0;
    assign io_bus.rf_addr  = 5'd0;
    assign io_bus.rf_wdata = 32'd0;
`endif

    assign io_bus.rx_ready  = r_rx_ready;
    assign io_bus.mem_we    = r_mem_we;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_wdata = r_mem_wdata;
    assign o_cpu_hold       = r_cpu_hold;
    assign o_cpu_start      = r_cpu_start;
    assign o_load_err       = r_load_err;
    assign o_words_loaded   = r_words_loaded;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader: normal load, gapped load, bad headers,
// reset mid-load, full-depth load and the optional register-bank init timing.
module tb_mips32_prog_loader;
    localparam int ADDR_W = 10;
`ifdef REGBANK_INIT_EN
    localparam int START_LAT = 34;
    localparam int RF_EXP    = 32;
`else
    localparam int START_LAT = 2;
    localparam int RF_EXP    = 0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cpu_hold;
    logic            cpu_start;
    logic            load_err;
    logic [ADDR_W:0] words_loaded;

    always #5 clk = ~clk;

    mips32_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    mips32_prog_loader #(
        .ADDR_W(ADDR_W), .MEM_DEPTH(1024), .BASE_ADDR(0)
    ) dut (
        .i_clk1         (clk),
        .i_reset        (rst),
        .io_bus         (bus),
        .o_cpu_hold     (cpu_hold),
        .o_cpu_start    (cpu_start),
        .o_load_err     (load_err),
        .o_words_loaded (words_loaded)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    logic [31:0] wr_addr [0:4095];
    logic [31:0] wr_data [0:4095];
    int          wr_cyc  [0:4095];
    int          wr_n = 0;
    logic [31:0] rf_a    [0:255];
    logic [31:0] rf_d    [0:255];
    int          rf_c    [0:255];
    int          rf_n = 0;
    int          start_n = 0;
    int          start_cyc = 0;

    logic [31:0] tx     [0:1023];
    int          tx_acc [0:1023];
    logic [31:0] prog   [0:8] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                                  32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                                  32'hfc000000};

    always @(posedge clk) cyc <= cyc + 1;

    // Observe strobes mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (bus.mem_we && wr_n < 4096) begin
            wr_addr[wr_n] <= 32'(bus.mem_addr);
            wr_data[wr_n] <= bus.mem_wdata;
            wr_cyc[wr_n]  <= cyc;
            wr_n          <= wr_n + 1;
        end
        if (bus.rf_we && rf_n < 256) begin
            rf_a[rf_n] <= 32'(bus.rf_addr);
            rf_d[rf_n] <= bus.rf_wdata;
            rf_c[rf_n] <= cyc;
            rf_n       <= rf_n + 1;
        end
        if (cpu_start) begin
            start_n   <= start_n + 1;
            start_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        acc_cyc      = cyc;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 3; k >= 0; k--) begin
            if (gap > 0) idle($urandom_range(0, gap));
            send_byte(w[k*8 +: 8]);
        end
    endtask

    task automatic reset_dut();
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        idle(2);
        rst          = 1'b0;
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, "_rdy"},   64'(bus.rx_ready), 64'd1);
        check({tag, "_hold"},  64'(cpu_hold),     64'd1);
        check({tag, "_start"}, 64'(cpu_start),    64'd0);
        check({tag, "_err"},   64'(load_err),     64'd0);
        check({tag, "_wl"},    64'(words_loaded), 64'd0);
        check({tag, "_we"},    64'(bus.mem_we),   64'd0);
    endtask

    task automatic run_load(input logic [31:0] hdr, input int n, input int gap);
        send_word(hdr, gap);
        for (int i = 0; i < n; i++) begin
            send_word(tx[i], gap);
            tx_acc[i] = acc_cyc;
        end
        check("rdy_drop", 64'(bus.rx_ready), 64'd0);
        idle(40);
    endtask

    task automatic check_load(input string t, input int n, input int bw, input int bs, input int br);
        int last;
        last = tx_acc[n-1];
        check({t, "_nwr"}, 64'(wr_n - bw), 64'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", t, i), 64'(wr_addr[bw+i]), 64'(i));
            check($sformatf("%s_data%0d", t, i), 64'(wr_data[bw+i]), 64'(tx[i]));
            check($sformatf("%s_wcyc%0d", t, i), 64'(wr_cyc[bw+i]),  64'(tx_acc[i] + 1));
        end
        check({t, "_wl"},     64'(words_loaded),  64'(n));
        check({t, "_nstart"}, 64'(start_n - bs),  64'd1);
        check({t, "_scyc"},   64'(start_cyc),     64'(last + START_LAT));
        check({t, "_hold"},   64'(cpu_hold),      64'd0);
        check({t, "_start"},  64'(cpu_start),     64'd0);
        check({t, "_rdy"},    64'(bus.rx_ready),  64'd0);
        check({t, "_err"},    64'(load_err),      64'd0);
        check({t, "_nrf"},    64'(rf_n - br),     64'(RF_EXP));
`ifdef REGBANK_INIT_EN
        for (int k = 0; k < 32; k++) begin
            check($sformatf("%s_rfa%0d", t, k), 64'(rf_a[br+k]), 64'(k));
            check($sformatf("%s_rfd%0d", t, k), 64'(rf_d[br+k]), 64'(k));
            check($sformatf("%s_rfc%0d", t, k), 64'(rf_c[br+k]), 64'(last + 2 + k));
        end
`endif
    endtask

    task automatic bad_header(input string t, input logic [31:0] hdr);
        int bw, bs;
        reset_dut();
        bw = wr_n;
        bs = start_n;
        send_word(hdr, 0);
        idle(3);
        check({t, "_err"},  64'(load_err),     64'd1);
        check({t, "_rdy"},  64'(bus.rx_ready), 64'd0);
        check({t, "_hold"}, 64'(cpu_hold),     64'd1);
        send_word(prog[0], 0);
        idle(5);
        check({t, "_nwr"},    64'(wr_n - bw),    64'd0);
        check({t, "_nstart"}, 64'(start_n - bs), 64'd0);
        check({t, "_err2"},   64'(load_err),     64'd1);
        check({t, "_wl"},     64'(words_loaded), 64'd0);
    endtask

    initial begin
        int bw, bs, br;
        bus.rx_data  = 8'd0;
        bus.rx_valid = 1'b0;
        reset_dut();
        check_idle_state("rst");

        // Back-to-back nine-word program
        for (int i = 0; i < 9; i++) tx[i] = prog[i];
        bw = wr_n; bs = start_n; br = rf_n;
        run_load(32'd9, 9, 0);
        check_load("t1", 9, bw, bs, br);

        // Same program with random valid gaps
        reset_dut();
        bw = wr_n; bs = start_n; br = rf_n;
        run_load(32'd9, 9, 5);
        check_load("t2", 9, bw, bs, br);

        bad_header("t3z", 32'h00000000);
        bad_header("t3o", 32'h00000401);

        // Reset in the middle of word 3, with a byte offered during reset
        reset_dut();
        bw = wr_n;
        send_word(32'd9, 0);
        for (int i = 0; i < 3; i++) send_word(prog[i], 0);
        send_byte(prog[3][31:24]);
        send_byte(prog[3][23:16]);
        idle(2);
        check("t4_pre_nwr", 64'(wr_n - bw), 64'd3);
        rst          = 1'b1;
        bus.rx_data  = 8'hFF;
        bus.rx_valid = 1'b1;
        idle(2);
        rst          = 1'b0;
        bus.rx_valid = 1'b0;
        idle(2);
        check("t4_post_nwr", 64'(wr_n - bw), 64'd3);
        check_idle_state("t4rst");
        bw = wr_n; bs = start_n; br = rf_n;
        run_load(32'd3, 3, 0);
        check_load("t4", 3, bw, bs, br);

        // Full-depth load ending at the last address
        reset_dut();
        for (int i = 0; i < 1024; i++) tx[i] = 32'hC000_0000 | 32'(i);
        bw = wr_n; bs = start_n; br = rf_n;
        run_load(32'd1024, 1024, 0);
        check_load("t5", 1024, bw, bs, br);
        check("t5_last_addr", 64'(wr_addr[bw+1023]), 64'd1023);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
